// File: rtl/adda_chan_sched.sv
// -----------------------------------------------------------------------------
// adda_chan_sched
//
// Round-robin scheduler that shares a single ADDA adder (DQL = DQLN + Y>>2)
// among NCH ADPCM channels. One requesting channel is granted at a time. Its
// operands are registered and DQL is computed in the following cycle. The
// result is then presented on a valid/ready output, tagged with the channel
// index, and held until the consumer accepts it. No new grant is issued while
// a result is pending.
//
// Ports
//   clk        in   1        system clock, rising edge
//   reset_n    in   1        asynchronous reset, active low
//   req_valid  in   NCH      per-channel request, bit i = channel i
//   req_dqln   in   NCH*12   channel i DQLN at [12*i+11:12*i]
//   req_y      in   NCH*13   channel i Y at [13*i+12:13*i]
//   req_ready  out  NCH      one-hot grant (combinational, IDLE only)
//   out_valid  out  1        out_dql/out_chan hold a result
//   out_ready  in   1        consumer accepts the result
//   out_dql    out  12       DQLN + Y[12:2], modulo 4096
//   out_chan   out  IDW      channel that produced out_dql
//   busy       out  1        a transaction is in flight (not IDLE)
// -----------------------------------------------------------------------------
module adda_chan_sched #(
    parameter int NCH = 4,
    parameter int IDW = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NCH-1:0]    req_valid,
    input  logic [NCH*12-1:0] req_dqln,
    input  logic [NCH*13-1:0] req_y,
    output logic [NCH-1:0]    req_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [11:0]       out_dql,
    output logic [IDW-1:0]    out_chan,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] grant_idx;
    logic           grant_any;
    logic           take;
    int             cand;
    logic [IDW-1:0] cidx;

    logic [11:0]    dqln_sel;
    logic [12:0]    y_sel;

    logic [11:0]    dqln_p0;
    logic [12:0]    y_p0;
    logic [IDW-1:0] chan_p0;

    // ADDA: scale factor contributes Y>>2 (11 bits); the carry out of the
    // 12-bit sum is discarded so the result wraps modulo 4096.
    function automatic logic [11:0] adda_wrap(input logic [11:0] dqln,
                                              input logic [12:0] y);
        logic [12:0] sum;
        sum = {1'b0, dqln} + {2'b00, y[12:2]};
        return sum[11:0];
    endfunction

    // Round-robin search: start just after the last granted channel and
    // wrap, so the channel granted most recently has the lowest priority.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cidx      = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand = int'(last_grant) + k;
            if (cand >= NCH) begin
                cand = cand - NCH;
            end
            cidx = IDW'(cand);
            if (!grant_any && req_valid[cidx]) begin
                grant_any = 1'b1;
                grant_idx = cidx;
            end
        end
    end

    assign take     = (state == IDLE) && grant_any;
    assign dqln_sel = req_dqln[grant_idx*12 +: 12];
    assign y_sel    = req_y[grant_idx*13 +: 13];
    assign busy     = (state != IDLE);

    // Grant is offered only in IDLE and is suppressed while reset is held,
    // so no handshake can appear to complete during reset.
    always_comb begin
        req_ready = '0;
        if (take && reset_n) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---- stage p0: capture granted channel (control) ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= IDW'(NCH - 1);
            chan_p0    <= '0;
            out_valid  <= 1'b0;
            out_dql    <= '0;
            out_chan   <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                last_grant <= grant_idx;
                chan_p0    <= grant_idx;
            end
            // ---- stage p1: adder result to output register ----
            if (state == CALC) begin
                out_valid <= 1'b1;
                out_dql   <= adda_wrap(dqln_p0, y_p0);
                out_chan  <= chan_p0;
            end else if ((state == HOLD) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // ---- stage p0: capture granted operands (data, no reset needed) ----
    always_ff @(posedge clk) begin
        if (take) begin
            dqln_p0 <= dqln_sel;
            y_p0    <= y_sel;
        end
    end

endmodule

// File: tb/tb_adda_chan_sched.sv
// -----------------------------------------------------------------------------
// tb_adda_chan_sched
//
// Self-checking bench for adda_chan_sched. A transaction-level model tracks
// the pending result, the round-robin pointer and the expected DQL, and is
// compared with the DUT on every falling clock edge. Directed scenarios add
// literal expectations for reset, arithmetic wrap, grant order, backpressure
// and reset during a calculation.
// -----------------------------------------------------------------------------
module tb_adda_chan_sched;

    localparam int NCH = 4;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NCH-1:0]    req_valid;
    logic [NCH*12-1:0] req_dqln;
    logic [NCH*13-1:0] req_y;
    logic [NCH-1:0]    req_ready;
    logic              out_valid;
    logic              out_ready;
    logic [11:0]       out_dql;
    logic [IDW-1:0]    out_chan;
    logic              busy;

    adda_chan_sched #(.NCH(NCH), .IDW(IDW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_dqln  (req_dqln),
        .req_y     (req_y),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dql   (out_dql),
        .out_chan  (out_chan),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model state: a transaction is either absent, waiting for its result,
    // or presenting its result.
    int m_lg      = NCH - 1;
    bit m_pending = 1'b0;
    bit m_ov      = 1'b0;
    int m_dql     = 0;
    int m_chan    = 0;
    int m_cap_dqln = 0;
    int m_cap_y    = 0;
    int m_cap_ch   = 0;

    int g_ch[$];
    int g_cyc[$];
    int o_ch[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_evt(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: expected event did not occur (t=%0t)", name, $time);
    endtask

    function automatic int exp_grant();
        int c;
        if (!reset_n || m_pending) return -1;
        for (int k = 1; k <= NCH; k++) begin
            c = (m_lg + k) % NCH;
            if (req_valid[c]) return c;
        end
        return -1;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Model update on each active edge (or immediately on reset).
    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_lg      = NCH - 1;
            m_pending = 1'b0;
            m_ov      = 1'b0;
            m_dql     = 0;
            m_chan    = 0;
        end else begin
            int g;
            g = exp_grant();
            if (m_ov) begin
                if (out_ready) begin
                    m_ov      = 1'b0;
                    m_pending = 1'b0;
                end
            end else if (m_pending) begin
                m_ov   = 1'b1;
                m_dql  = (m_cap_dqln + m_cap_y / 4) % 4096;
                m_chan = m_cap_ch;
            end else if (g >= 0) begin
                m_cap_dqln = int'(req_dqln[12*g +: 12]);
                m_cap_y    = int'(req_y[13*g +: 13]);
                m_cap_ch   = g;
                m_pending  = 1'b1;
                m_lg       = g;
            end
        end
    end

    // Compare process: every falling edge.
    initial forever begin
        int g;
        logic [NCH-1:0] exp_rr;
        @(negedge clk);
        g = exp_grant();
        exp_rr = (g >= 0) ? (NCH'(1) << g) : '0;
        check("req_ready", 32'(req_ready), 32'(exp_rr));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("out_dql",   32'(out_dql),   32'(m_dql));
        check("out_chan",  32'(out_chan),  32'(m_chan));
        check("busy",      32'(busy),      32'(m_pending));
        if (reset_n && ((req_ready & req_valid) != '0)) begin
            for (int i = 0; i < NCH; i++) begin
                if (req_ready[i]) begin
                    g_ch.push_back(i);
                    g_cyc.push_back(cyc);
                end
            end
        end
        if (reset_n && out_valid && out_ready) begin
            o_ch.push_back(int'(out_chan));
        end
    end

    task automatic set_ch(input int ch, input logic [11:0] d, input logic [12:0] y);
        req_dqln[12*ch +: 12] = d;
        req_y[13*ch +: 13]    = y;
    endtask

    // Single channel request from IDLE; returns in the first HOLD cycle.
    task automatic do_single(input int ch, input logic [11:0] d,
                             input logic [12:0] y, input logic [11:0] exp_dql);
        @(posedge clk);
        #1;
        set_ch(ch, d, y);
        req_valid = NCH'(1) << ch;
        #1;
        check("single_req_ready", 32'(req_ready), 32'(NCH'(1) << ch));
        @(posedge clk);
        #1;
        req_valid = '0;
        @(posedge clk);
        #1;
        check("single_out_valid", 32'(out_valid), 32'd1);
        check("single_out_dql",   32'(out_dql),   32'(exp_dql));
        check("single_out_chan",  32'(out_chan),  32'(ch));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ord[6];
        ord = '{0, 1, 2, 3, 0, 1};
        reset_n   = 1'b0;
        req_valid = '0;
        req_dqln  = '0;
        req_y     = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset asserted mid-cycle while a result is held.
        do_single(1, 12'h123, 13'h0040, 12'h133);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_dql",   32'(out_dql),   32'd0);
        check("rst_out_chan",  32'(out_chan),  32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Basic and wrapping arithmetic.
        do_single(0, 12'h100, 13'h0400, 12'h200);
        do_single(1, 12'hFFF, 13'h0008, 12'h001);
        do_single(3, 12'h800, 13'h1FFF, 12'hFFF);

        // All channels requesting continuously.
        @(posedge clk);
        #1;
        g_ch.delete();
        g_cyc.delete();
        o_ch.delete();
        set_ch(0, 12'h010, 13'h0020);
        set_ch(1, 12'hF00, 13'h1000);
        set_ch(2, 12'h555, 13'h0AAA);
        set_ch(3, 12'hFFE, 13'h000C);
        req_valid = '1;
        for (int i = 0; i < 60 && g_ch.size() < 6; i++) @(negedge clk);
        if (g_ch.size() < 6) fail_evt("rr_grant_count");
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (4) @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            if (g_ch.size() > i) check("rr_grant_order", 32'(g_ch[i]), 32'(ord[i]));
            else fail_evt("rr_grant_missing");
            if (i > 0 && g_cyc.size() > i)
                check("rr_grant_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'd3);
            if (o_ch.size() > i) check("rr_out_order", 32'(o_ch[i]), 32'(ord[i]));
            else fail_evt("rr_out_missing");
        end

        // Backpressure: ch2 wins over ch0, result held for several cycles.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        set_ch(2, 12'h0AB, 13'h0100);
        set_ch(0, 12'h7F0, 13'h0044);
        req_valid = 4'b0101;
        #1;
        check("bp_first_grant", 32'(req_ready), 32'b0100);
        @(posedge clk);
        #1;
        req_valid = 4'b0001;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_dql",   32'(out_dql),   32'h0EB);
            check("bp_out_chan",  32'(out_chan),  32'd2);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_busy",      32'(busy),      32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_next_grant",    32'(req_ready), 32'b0001);
        check("bp_release_busy",  32'(busy),      32'd0);
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (3) @(posedge clk);

        // Reset during CALC after granting ch2.
        @(posedge clk);
        #1;
        set_ch(2, 12'h3C0, 13'h0010);
        req_valid = 4'b0100;
        #1;
        check("rc_grant", 32'(req_ready), 32'b0100);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        req_valid = '1;
        #1;
        check("rc_out_valid", 32'(out_valid), 32'd0);
        check("rc_busy",      32'(busy),      32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rc_hold_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        check("rc_first_grant", 32'(req_ready), 32'b0001);
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (4) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
